// File: rtl/eth_tx_axis_framer.sv
// eth_tx_axis_framer: store-and-forward 64-bit frame buffer emitting padded AXI-Stream frames to a 10G MAC
module eth_tx_axis_framer #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [63:0] wr_data,
  output logic        wr_ready,
  input  logic        cmd_valid,
  input  logic [10:0] cmd_len,
  output logic        cmd_ready,
  output logic [63:0] eth_tx_axis_tdata,
  output logic [7:0]  eth_tx_axis_tkeep,
  output logic        eth_tx_axis_tlast,
  output logic        eth_tx_axis_tuser,
  output logic        eth_tx_axis_tvalid,
  input  logic        eth_tx_axis_tready,
  output logic [31:0] frames_sent,
  output logic [15:0] frames_dropped
);
  localparam int FW = DEPTH_LOG2 + 1;
  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;
  state_t state_q, state_d;
  logic [63:0] mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FW-1:0] fill_q;
  logic [10:0] len_q;
  logic [8:0] words_q, beats_q, beat_q, cmd_words;
  logic [63:0] tdata_q, beat_data;
  logic [7:0] tkeep_q, last_keep;
  logic tlast_q, tvalid_q, push, pop, load, cmd_fire, is_last, accept;
  logic [2:0] rem;
  logic [31:0] sent_q;
  logic [15:0] dropped_q;
  assign wr_ready = ~fill_q[DEPTH_LOG2];
  assign cmd_ready = (state_q == IDLE) && !reset;
  assign push = wr_valid & wr_ready;
  assign cmd_fire = cmd_valid & cmd_ready;
  assign cmd_words = 9'(({1'b0, cmd_len} + 12'd7) >> 3);
  assign accept = tvalid_q & eth_tx_axis_tready;
  assign load = (state_q == SEND) && (!tvalid_q || eth_tx_axis_tready) && (beat_q != beats_q);
  assign pop = load && (beat_q < words_q);
  assign is_last = beat_q == beats_q - 9'd1;
  // frames shorter than 60 bytes are padded to 60, which ends 4 bytes into the last beat
  assign rem = len_q < 11'd60 ? 3'd4 : len_q[2:0];
  assign last_keep = rem == 3'd0 ? 8'hFF : ~(8'hFF << rem);
  always_comb begin
    beat_data = '0;
    for (int i = 0; i < 8; i++)
      beat_data[8*i +: 8] = ({beat_q, 3'b000} + 12'(i) < {1'b0, len_q}) ? mem_q[rd_ptr_q][8*i +: 8] : 8'h00;
  end
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? ((cmd_fire && cmd_len != 11'd0) ? WAIT : IDLE)
            : state_q == WAIT ? ((fill_q >= FW'(words_q)) ? SEND : WAIT)
            : ((accept && tlast_q) ? IDLE : SEND);
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      len_q     <= '0;
      words_q   <= '0;
      beats_q   <= '0;
      beat_q    <= '0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      sent_q    <= '0;
      dropped_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(push);
      rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(pop);
      fill_q   <= fill_q + FW'(push) - FW'(pop);
      if (cmd_fire && cmd_len == 11'd0) dropped_q <= dropped_q + 16'(dropped_q != 16'hFFFF);
      if (cmd_fire) begin
        len_q   <= cmd_len;
        words_q <= cmd_words;
        beats_q <= cmd_len < 11'd60 ? 9'd8 : cmd_words;
        beat_q  <= '0;
      end
      // the output register refills whenever it is empty or its beat is being taken
      if (load) begin
        tdata_q  <= beat_data;
        tkeep_q  <= is_last ? last_keep : 8'hFF;
        tlast_q  <= is_last;
        tvalid_q <= 1'b1;
        beat_q   <= beat_q + 9'd1;
      end else if (accept) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
      if (accept && tlast_q) sent_q <= sent_q + 32'd1;
    end
  end
  assign eth_tx_axis_tdata  = tdata_q;
  assign eth_tx_axis_tkeep  = tkeep_q;
  assign eth_tx_axis_tlast  = tlast_q;
  assign eth_tx_axis_tuser  = 1'b0;
  assign eth_tx_axis_tvalid = tvalid_q;
  assign frames_sent        = sent_q;
  assign frames_dropped     = dropped_q;
endmodule

// File: tb/tb_eth_tx_axis_framer.sv
// tb_eth_tx_axis_framer: table of frame vectors plus hand sequences; a beat scoreboard models padding, masking and tkeep
module tb_eth_tx_axis_framer;
  localparam int DL2 = 9;
  localparam int DEPTH = 1 << DL2;
  logic clock = 0, reset = 1, wr_valid = 0, cmd_valid = 0, tready = 1, rnd_mode = 0;
  logic [63:0] wr_data = '0;
  logic [10:0] cmd_len = '0;
  logic wr_ready, cmd_ready, tlast, tuser, tvalid;
  logic [63:0] tdata;
  logic [7:0] tkeep;
  logic [31:0] frames_sent;
  logic [15:0] frames_dropped;
  int compared = 0, mismatched = 0;
  typedef struct {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
  typedef struct {int len; int extra; int beats; logic [7:0] last_keep;} vec_t;
  beat_t exp_q[$];
  logic [63:0] stream_q[$], pend_q[$];
  int batch_q[$];
  int beats_seen = 0, exp_sent = 0, exp_dropped = 0;
  logic [7:0] last_keep_seen = '0;
  logic stalled = 0;
  logic [73:0] held = '0;
  vec_t vecs[10];

  eth_tx_axis_framer #(.DEPTH_LOG2(DL2)) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .eth_tx_axis_tdata(tdata), .eth_tx_axis_tkeep(tkeep), .eth_tx_axis_tlast(tlast),
    .eth_tx_axis_tuser(tuser), .eth_tx_axis_tvalid(tvalid), .eth_tx_axis_tready(tready),
    .frames_sent(frames_sent), .frames_dropped(frames_dropped)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out, expected completion", name);
  endtask

  function automatic void gen_words(input int len, input int extra, input bit scramble);
    logic [63:0] r, w;
    r = scramble ? {$urandom, $urandom} : 64'd0;
    for (int k = 0; k < (len + 7) / 8 + extra; k++) begin
      w = (64'h0706050403020100 + 64'(k) * 64'h0808080808080808) ^ r;
      pend_q.push_back(w);
      stream_q.push_back(w);
    end
  endfunction

  function automatic void push_expect(input int len);
    int w, el, b;
    logic [63:0] wd[$];
    logic [63:0] cw;
    beat_t e;
    if (len == 0) begin
      if (exp_dropped < 65535) exp_dropped++;
      return;
    end
    w = (len + 7) / 8;
    el = len < 60 ? 60 : len;
    b = (el + 7) / 8;
    for (int k = 0; k < w; k++) wd.push_back(stream_q.size() > 0 ? stream_q.pop_front() : 64'd0);
    for (int j = 0; j < b; j++) begin
      cw = j < w ? wd[j] : 64'd0;
      for (int i = 0; i < 8; i++) begin
        e.d[8*i +: 8] = (8*j + i < len) ? cw[8*i +: 8] : 8'h00;
        e.k[i] = 8*j + i < el;
      end
      e.l = j == b - 1;
      exp_q.push_back(e);
    end
    exp_sent++;
  endfunction

  // monitor: scoreboard pop on each accepted beat, and hold check across stalls
  initial forever begin
    @(negedge clock);
    if (stalled && !reset) check("hold", {tvalid, tlast, tkeep, tdata}, held);
    stalled = tvalid && !tready;
    held = {tvalid, tlast, tkeep, tdata};
    if (tvalid && tready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_beat: got tdata %0h, expected no beat", tdata);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat", {tuser, tlast, tkeep, tdata}, {1'b0, e.l, e.k, e.d});
      end
      beats_seen++;
      if (tlast) last_keep_seen = tkeep;
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic write_word(input logic [63:0] d);
    int n = 0;
    @(negedge clock);
    while (!wr_ready && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 5000) begin
      fail_timeout("write");
      return;
    end
    wr_valid = 1;
    wr_data = d;
    @(posedge clock);
    #1;
    wr_valid = 0;
  endtask

  task automatic send_cmd(input int len);
    int n = 0;
    @(negedge clock);
    while (!cmd_ready && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 5000) begin
      fail_timeout("cmd_accept");
      return;
    end
    cmd_valid = 1;
    cmd_len = 11'(len);
    @(posedge clock);
    #1;
    cmd_valid = 0;
    push_expect(len);
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(exp_q.size() == 0 && !tvalid && cmd_ready) && n < 5000);
    if (n >= 5000) fail_timeout("drain");
  endtask

  task automatic start_batch();
    fork
      while (pend_q.size() > 0) write_word(pend_q.pop_front());
      foreach (batch_q[i]) send_cmd(batch_q[i]);
    join
    batch_q.delete();
  endtask

  task automatic run_frame(input int len, input int extra, input bit scramble);
    gen_words(len, extra, scramble);
    batch_q.push_back(len);
    start_batch();
    wait_drain();
  endtask

  initial begin
    int b0, n;
    vecs[0] = '{64, 0, 8, 8'hFF};
    vecs[1] = '{13, 0, 8, 8'h0F};
    vecs[2] = '{60, 0, 8, 8'h0F};
    vecs[3] = '{61, 0, 8, 8'h1F};
    vecs[4] = '{1, 0, 8, 8'h0F};
    vecs[5] = '{8, 0, 8, 8'h0F};
    vecs[6] = '{59, 0, 8, 8'h0F};
    vecs[7] = '{2047, 0, 256, 8'h7F};
    vecs[8] = '{1514, 0, 190, 8'h03};
    vecs[9] = '{65, 3, 9, 8'h01};
    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tkeep", tkeep, 0);
    check("rst_tlast", tlast, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_frames_sent", frames_sent, 0);
    check("rst_frames_dropped", frames_dropped, 0);
    @(posedge clock);
    #1;
    reset = 0;
    @(negedge clock);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_wr_ready", wr_ready, 1);
    // store-and-forward wait with one word missing, then exact tvalid latency
    b0 = beats_seen;
    gen_words(70, 0, 1);
    send_cmd(70);
    repeat (8) write_word(pend_q.pop_front());
    repeat (20) @(negedge clock);
    check("wait_no_beats", beats_seen - b0, 0);
    check("wait_tvalid", tvalid, 0);
    check("wait_cmd_ready", cmd_ready, 0);
    write_word(pend_q.pop_front());
    @(negedge clock);
    check("lat_cycle0", tvalid, 0);
    @(negedge clock);
    check("lat_cycle1", tvalid, 0);
    @(negedge clock);
    check("lat_cycle2", tvalid, 1);
    wait_drain();
    check("len70_beats", beats_seen - b0, 9);
    check("len70_last_keep", last_keep_seen, 8'h3F);
    check("len70_frames_sent", frames_sent, exp_sent);
    // zero-length descriptor is dropped
    b0 = beats_seen;
    send_cmd(0);
    @(negedge clock);
    check("drop_count", frames_dropped, exp_dropped);
    check("drop_cmd_ready", cmd_ready, 1);
    repeat (10) @(negedge clock);
    check("drop_no_beats", beats_seen - b0, 0);
    // vector table under random backpressure
    rnd_mode = 1;
    foreach (vecs[i]) begin
      b0 = beats_seen;
      run_frame(vecs[i].len, vecs[i].extra, i != 0);
      check($sformatf("v%0d_beats", i), beats_seen - b0, vecs[i].beats);
      check($sformatf("v%0d_last_keep", i), last_keep_seen, vecs[i].last_keep);
      check($sformatf("v%0d_frames_sent", i), frames_sent, exp_sent);
    end
    // three back-to-back max frames, overflowing the buffer depth while draining
    b0 = beats_seen;
    repeat (3) begin
      gen_words(1514, 0, 1);
      batch_q.push_back(1514);
    end
    start_batch();
    wait_drain();
    check("b2b_beats", beats_seen - b0, 570);
    check("b2b_last_keep", last_keep_seen, 8'h03);
    check("b2b_frames_sent", frames_sent, exp_sent);
    check("b2b_dropped", frames_dropped, exp_dropped);
    // fill to full; leftover words from the extra-word vector still occupy the buffer
    rnd_mode = 0;
    n = 0;
    @(negedge clock);
    while (wr_ready && n < DEPTH + 8) begin
      wr_valid = 1;
      wr_data = 64'(n);
      @(posedge clock);
      #1;
      wr_valid = 0;
      n++;
      @(negedge clock);
    end
    check("full_words", n, DEPTH - stream_q.size());
    check("full_wr_ready", wr_ready, 0);
    reset = 1;
    @(posedge clock);
    #1;
    exp_q.delete();
    stream_q.delete();
    pend_q.delete();
    exp_sent = 0;
    exp_dropped = 0;
    @(negedge clock);
    check("full_rst_wr_ready", wr_ready, 1);
    @(posedge clock);
    #1;
    reset = 0;
    // reset while beat 4 of a 64-byte frame is on the bus
    b0 = beats_seen;
    gen_words(64, 0, 1);
    batch_q.push_back(64);
    start_batch();
    n = 0;
    while (beats_seen - b0 < 3 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 200) fail_timeout("midframe_beat3");
    reset = 1;
    @(posedge clock);
    #1;
    exp_q.delete();
    stream_q.delete();
    pend_q.delete();
    exp_sent = 0;
    exp_dropped = 0;
    @(negedge clock);
    check("mid_rst_tvalid", tvalid, 0);
    check("mid_rst_tlast", tlast, 0);
    check("mid_rst_beats", beats_seen - b0, 4);
    check("mid_rst_frames_sent", frames_sent, 0);
    check("mid_rst_frames_dropped", frames_dropped, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_wr_ready", wr_ready, 1);
    reset = 0;
    b0 = beats_seen;
    run_frame(64, 0, 1);
    check("after_rst_beats", beats_seen - b0, 8);
    check("after_rst_last_keep", last_keep_seen, 8'hFF);
    check("after_rst_frames_sent", frames_sent, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
